detector_frame_sequencer: RTL
=============================

Name: detector_frame_sequencer

Overview:
- Controller in front of the object_detector cell array. Takes a pixel stream over a valid/ready handshake and sequences it into whole frames.
- Drives the detector's mode, write strobe and data, and owns the training-to-detection transition.
- Re-frames the detector's result stream with a last-pixel marker and keeps per-frame counters.
- Sits between the camera/DMA pixel source and the detector; the only block that writes the detector.

Parameters:
- NUM_PIXELS, 100, pixels per frame (numRows*numColumn of the detector).
- DATA_W, 8, pixel width.
- MAX_TRAIN_FRAMES, 16, training frames allowed before a training timeout is flagged.
- CNT_W, 16, width of the frame counters.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins training from IDLE.
- i_abort  in  1  one-cycle pulse; abandons the current frame.
- s_pix_data  in  DATA_W  source pixel.
- s_pix_valid  in  1  source pixel valid.
- s_pix_ready  out  1  sequencer accepts the pixel this cycle.
- o_det_reset  out  1  active-high synchronous reset to the detector.
- o_det_mode  out  1  detector i_mode; 1 = training, 0 = detect.
- o_det_wr  out  1  detector i_img_mem_wr.
- o_det_data  out  DATA_W  detector i_img_data.
- i_det_done_training  in  1  detector o_done_training.
- i_det_data_valid  in  1  detector o_img_data_valid.
- i_det_data  in  DATA_W  detector o_img_data.
- m_res_data  out  DATA_W  result pixel.
- m_res_valid  out  1  result pixel valid; no backpressure.
- m_res_last  out  1  marks the last pixel of a result frame.
- o_state  out  3  current FSM state encoding.
- o_train_frames  out  CNT_W  completed training frames.
- o_det_frames  out  CNT_W  completed detection frames.
- o_train_timeout  out  1  sticky; cleared by reset or i_start.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - State = IDLE; all counters = 0.
  - o_det_reset = 1. It stays high for 2 cycles after deassertion, then goes to 0.
  - s_pix_ready = 0, o_det_wr = 0, o_det_data = 0, o_det_mode = 1.
  - m_res_valid = 0, m_res_last = 0, m_res_data = 0, o_train_timeout = 0.
- Handshake: a pixel transfers when s_pix_valid and s_pix_ready are both 1. s_pix_ready = 1 only in TRAIN and DETECT.
- Write path timing: on each transfer, the next cycle has o_det_wr = 1 and o_det_data = s_pix_data, both registered. Latency is exactly 1 cycle.
- pix_cnt:
  - Counts transfers 0..NUM_PIXELS-1.
  - Wraps to 0 on the transfer where pix_cnt == NUM_PIXELS-1. That transfer is the frame end.
  - Frames are always written whole; the detector write pointer must stay aligned to pixel 0.
- FSM states: IDLE, TRAIN, TRAIN_CHK, DETECT, DRAIN, ABORT.
  - IDLE: on i_start, clear train/det counters and timeout, set o_det_mode = 1, go to TRAIN.
  - TRAIN: on frame end, o_train_frames++, go to TRAIN_CHK.
  - TRAIN_CHK (s_pix_ready = 0; one check cycle, then evaluate):
    - If i_det_done_training = 1: o_det_mode = 0, go to DETECT.
    - Else if o_train_frames == MAX_TRAIN_FRAMES: set o_train_timeout, go to IDLE.
    - Else: go to TRAIN.
  - DETECT: on frame end, go to DRAIN.
  - DRAIN (s_pix_ready = 0): wait until res_cnt wraps (NUM_PIXELS results received), o_det_frames++, go to DETECT.
  - ABORT: see abort rules below.
- Result path:
  - The detector presents data one cycle after its valid. On each cycle following an i_det_data_valid pulse, register i_det_data into m_res_data and pulse m_res_valid.
  - res_cnt counts results 0..NUM_PIXELS-1; m_res_last = 1 when res_cnt == NUM_PIXELS-1.
  - Back-to-back valid pulses must be handled every cycle.
  - i_det_data_valid while o_det_mode = 1 is ignored.
- Abort:
  - i_abort in any state other than IDLE: go to ABORT; s_pix_ready = 0 the same cycle.
  - An in-flight o_det_wr still completes.
  - In ABORT: assert o_det_reset for 2 cycles and clear pix_cnt and res_cnt.
  - Exit ABORT to IDLE; the detector must be retrained.
- Priorities:
  - i_abort has priority over i_start and over a frame end in the same cycle.
  - i_start outside IDLE is ignored.
- Counters saturate at all-ones; they do not wrap.

Decomposition:
- Shared package detector_pkg holds:
  - the state enum;
  - NUM_PIXELS derived from the numRows/numColumn constants;
  - DATA_W and CNT_W.
- One sub-module, frame_pixel_counter: modulo-N counter with enable, clear and wrap pulse. It is instantiated twice, for pix_cnt and res_cnt.

Test Plan:
- Reset mid-frame: drop i_reset_n at pixel 37 of a training frame -> all outputs at reset values immediately; o_det_reset high 2 cycles after release; pixel 0 of the next frame lands in cell 0.
- Training then detect: i_start, stream 3 frames of 100 pixels, with the detector model raising done_training after frame 3 -> o_train_frames = 3, o_det_mode falls in TRAIN_CHK, state = DETECT.
- Detect frame: stream 100 pixels 0..99 -> 100 m_res_valid pulses; m_res_last only on the 100th; o_det_frames = 1; s_pix_ready = 0 throughout DRAIN.
- Timeout: done_training held 0 -> after 16 frames o_train_timeout = 1, state = IDLE; the next i_start clears the timeout.
- Backpressure and bubbles: random s_pix_valid gaps -> o_det_wr count equals the transfer count; each o_det_data equals the accepted pixel, 1 cycle later.
- Abort collision: i_abort on the same cycle as the frame-end transfer -> state = ABORT (not TRAIN_CHK/DRAIN); o_det_reset 2 cycles; then IDLE with pix_cnt = 0.

Source files
------------

// File: rtl/detector_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
// Shared constants and types for the detector frame sequencer slice.
//   NUM_ROWS / NUM_COLUMNS : geometry of the object_detector cell array
//   NUM_PIXELS             : pixels per frame, derived from the geometry
//   DATA_W                 : pixel width
//   CNT_W                  : width of the per-frame counters
//   MAX_TRAIN_FRAMES       : training frames allowed before a timeout
//   state_t                : sequencer FSM states; the encoding is visible on o_state
// -----------------------------------------------------------------------------
package detector_pkg;

    localparam int NUM_ROWS         = 10;
    localparam int NUM_COLUMNS      = 10;
    localparam int NUM_PIXELS       = NUM_ROWS * NUM_COLUMNS;
    localparam int DATA_W           = 8;
    localparam int CNT_W            = 16;
    localparam int MAX_TRAIN_FRAMES = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRAIN     = 3'd1,
        ST_TRAIN_CHK = 3'd2,
        ST_DETECT    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_ABORT     = 3'd5
    } state_t;

endpackage

// File: rtl/detector_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// detector_frame_sequencer_if
// Pixel source stream (valid/ready) and result stream (valid/last, no
// backpressure) of the detector frame sequencer.
//   s_pix_data/s_pix_valid/s_pix_ready : source pixels into the sequencer
//   m_res_data/m_res_valid/m_res_last  : re-framed detector results out
// Modports: slave = the sequencer, master = the surrounding pixel source/sink.
// -----------------------------------------------------------------------------
interface detector_frame_sequencer_if
    import detector_pkg::*;
#(
    parameter int DATA_W = detector_pkg::DATA_W
);

    logic [DATA_W-1:0] s_pix_data;
    logic              s_pix_valid;
    logic              s_pix_ready;
    logic [DATA_W-1:0] m_res_data;
    logic              m_res_valid;
    logic              m_res_last;

    modport master (
        output s_pix_data, s_pix_valid,
        input  s_pix_ready,
        input  m_res_data, m_res_valid, m_res_last
    );

    modport slave (
        input  s_pix_data, s_pix_valid,
        output s_pix_ready,
        output m_res_data, m_res_valid, m_res_last
    );

endinterface

// File: rtl/detector_frame_sequencer_frame_pixel_counter.sv
// -----------------------------------------------------------------------------
// frame_pixel_counter
// Modulo-N counter used to track position within a frame.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_en             : advance by one
//   i_clr            : return to zero (wins over i_en)
//   o_wrap           : combinational pulse on the advance that leaves N-1
// -----------------------------------------------------------------------------
module frame_pixel_counter
    import detector_pkg::*;
#(
    parameter int N = NUM_PIXELS
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_reg;
    logic         at_last;

    assign at_last = (cnt_reg == W'(N - 1));
    assign o_wrap  = i_en && at_last && !i_clr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_reg <= '0;
        end else if (i_clr) begin
            cnt_reg <= '0;
        end else if (i_en) begin
            cnt_reg <= at_last ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/detector_frame_sequencer.sv
// -----------------------------------------------------------------------------
// detector_frame_sequencer
// Sole writer of the object_detector array: accepts a pixel stream, writes it
// to the detector in whole frames, runs the training -> detection hand-over,
// and re-frames detector results with a last-pixel marker.
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_start, i_abort          : one-cycle command pulses
//   pix_if (slave)            : source pixels in, results out
//   o_det_reset/mode/wr/data  : detector control and write port
//   i_det_done_training       : detector training complete
//   i_det_data_valid/data     : detector results (data lags valid by 1 cycle)
//   o_state                   : FSM state encoding
//   o_train_frames/det_frames : saturating completed-frame counters
//   o_train_timeout           : sticky, set when training never converges
// -----------------------------------------------------------------------------
module detector_frame_sequencer
    import detector_pkg::*;
#(
    parameter int NUM_PIXELS       = detector_pkg::NUM_PIXELS,
    parameter int DATA_W           = detector_pkg::DATA_W,
    parameter int MAX_TRAIN_FRAMES = detector_pkg::MAX_TRAIN_FRAMES,
    parameter int CNT_W            = detector_pkg::CNT_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic                      i_abort,
    detector_frame_sequencer_if.slave pix_if,
    output logic                      o_det_reset,
    output logic                      o_det_mode,
    output logic                      o_det_wr,
    output logic [DATA_W-1:0]         o_det_data,
    input  logic                      i_det_done_training,
    input  logic                      i_det_data_valid,
    input  logic [DATA_W-1:0]         i_det_data,
    output logic [2:0]                o_state,
    output logic [CNT_W-1:0]          o_train_frames,
    output logic [CNT_W-1:0]          o_det_frames,
    output logic                      o_train_timeout
);

    state_t             state_reg, state_next;
    logic               mode_reg, mode_next;
    logic [CNT_W-1:0]   train_frames_reg, train_frames_next;
    logic [CNT_W-1:0]   det_frames_reg, det_frames_next;
    logic               timeout_reg, timeout_next;
    logic [1:0]         det_rst_cnt_reg;
    logic               det_wr_reg;
    logic [DATA_W-1:0]  det_data_reg;
    logic               res_pend_reg;
    logic               res_valid_reg;
    logic               res_last_reg;
    logic [DATA_W-1:0]  res_data_reg;

    logic abort_go;
    logic cnt_clr;
    logic pix_xfer;
    logic pix_wrap;
    logic res_wrap;

    // Abort is ignored in IDLE; it also drops ready in the same cycle so the
    // frame-end transfer of a colliding abort never happens.
    assign abort_go = i_abort && (state_reg != ST_IDLE);
    assign cnt_clr  = (state_reg == ST_ABORT);

    assign pix_if.s_pix_ready = ((state_reg == ST_TRAIN) || (state_reg == ST_DETECT)) && !i_abort;
    assign pix_xfer           = pix_if.s_pix_valid && pix_if.s_pix_ready;

    frame_pixel_counter #(.N(NUM_PIXELS)) u_pix_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (pix_xfer),
        .i_clr     (cnt_clr),
        .o_wrap    (pix_wrap)
    );

    // Counts results as they are captured, so its wrap lines up with the
    // capture of the last result of a frame.
    frame_pixel_counter #(.N(NUM_PIXELS)) u_res_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (res_pend_reg),
        .i_clr     (cnt_clr),
        .o_wrap    (res_wrap)
    );

    always_comb begin
        state_next        = state_reg;
        mode_next         = mode_reg;
        train_frames_next = train_frames_reg;
        det_frames_next   = det_frames_reg;
        timeout_next      = timeout_reg;
        if (abort_go) begin
            state_next = ST_ABORT;
            mode_next  = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        train_frames_next = '0;
                        det_frames_next   = '0;
                        timeout_next      = 1'b0;
                        mode_next         = 1'b1;
                        state_next        = ST_TRAIN;
                    end
                end
                ST_TRAIN: begin
                    if (pix_wrap) begin
                        train_frames_next = (&train_frames_reg) ? train_frames_reg
                                                                : train_frames_reg + CNT_W'(1);
                        state_next        = ST_TRAIN_CHK;
                    end
                end
                ST_TRAIN_CHK: begin
                    if (i_det_done_training) begin
                        mode_next  = 1'b0;
                        state_next = ST_DETECT;
                    end else if (train_frames_reg >= CNT_W'(MAX_TRAIN_FRAMES)) begin
                        timeout_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        state_next = ST_TRAIN;
                    end
                end
                ST_DETECT: begin
                    if (pix_wrap) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (res_wrap) begin
                        det_frames_next = (&det_frames_reg) ? det_frames_reg
                                                            : det_frames_reg + CNT_W'(1);
                        state_next      = ST_DETECT;
                    end
                end
                ST_ABORT: begin
                    // Leave on the last cycle of the two-cycle detector reset.
                    if (det_rst_cnt_reg <= 2'd1) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg        <= ST_IDLE;
            mode_reg         <= 1'b1;
            train_frames_reg <= '0;
            det_frames_reg   <= '0;
            timeout_reg      <= 1'b0;
            det_rst_cnt_reg  <= 2'd2;
            det_wr_reg       <= 1'b0;
            det_data_reg     <= '0;
            res_pend_reg     <= 1'b0;
            res_valid_reg    <= 1'b0;
            res_last_reg     <= 1'b0;
            res_data_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            mode_reg         <= mode_next;
            train_frames_reg <= train_frames_next;
            det_frames_reg   <= det_frames_next;
            timeout_reg      <= timeout_next;
            // Detector reset is held for two cycles after power-up reset and
            // after every abort.
            if (abort_go) begin
                det_rst_cnt_reg <= 2'd2;
            end else if (det_rst_cnt_reg != 2'd0) begin
                det_rst_cnt_reg <= det_rst_cnt_reg - 2'd1;
            end
            det_wr_reg <= pix_xfer;
            if (pix_xfer) begin
                det_data_reg <= pix_if.s_pix_data;
            end
            // Detector data trails its valid by one cycle: remember the valid,
            // capture the data on the following cycle.
            res_pend_reg  <= i_det_data_valid && !mode_reg;
            res_valid_reg <= res_pend_reg;
            if (res_pend_reg) begin
                res_data_reg <= i_det_data;
            end
            res_last_reg <= res_wrap;
        end
    end

    assign o_det_reset        = (det_rst_cnt_reg != 2'd0);
    assign o_det_mode         = mode_reg;
    assign o_det_wr           = det_wr_reg;
    assign o_det_data         = det_data_reg;
    assign pix_if.m_res_data  = res_data_reg;
    assign pix_if.m_res_valid = res_valid_reg;
    assign pix_if.m_res_last  = res_last_reg;
    assign o_state            = state_reg;
    assign o_train_frames     = train_frames_reg;
    assign o_det_frames       = det_frames_reg;
    assign o_train_timeout    = timeout_reg;

endmodule
